hue_sequencer: RTL and testbench
================================

HUE_SEQUENCER -- requirements
Module: hue_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of LED channels on the colour wheel; legal range 2..8.
REQ-002 SHALL have parameter PWM_PERIOD, default 46875: PWM period in clk cycles; legal range 2..65535.
REQ-003 SHALL have parameter PERIODS_PER_STEP, default 1: PWM periods per brightness step; legal range 1..255.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: when 1, an asserted LED drives 0.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 SHALL have port run_i  input  1  1 advances brightness; 0 freezes level and state while PWM continues.
REQ-008 SHALL have port restart_i  input  1  one-cycle request to return to state 0, level 0.
REQ-009 SHALL have port led_o  output  CHANNELS  registered LED drive, polarity per ACTIVE_LOW.
REQ-010 SHALL have port state_o  output  $clog2(2*CHANNELS)  current hue state.
REQ-011 SHALL have port segment_done_o  output  1  one-cycle pulse on each state advance.

Function
REQ-012 SHALL run PWM counter cnt 0..PWM_PERIOD-1, wrapping to 0; period end = (cnt == PWM_PERIOD-1).
REQ-013 SHALL compute channel PWM as (cnt < duty_q); duty_q is reloaded only at period end, so a new duty takes effect at the next cnt=0 (glitch-free).
REQ-014 SHALL keep level 0..PWM_PERIOD (width $clog2(PWM_PERIOD+1)) and step prescaler 0..PERIODS_PER_STEP-1, both advancing only at period end with run_i=1.
REQ-015 SHALL, on prescaler wrap: if level==PWM_PERIOD, set level to 0, advance state (2*CHANNELS-1 wraps to 0) and pulse segment_done_o on the next cycle; else increment level.
REQ-016 SHALL map state 2i (even): channel i fully on, channel (i+1) mod CHANNELS rising with duty=level, all others off.
REQ-017 SHALL map state 2i+1 (odd): channel i falling with duty=PWM_PERIOD-level, channel (i+1) mod CHANNELS fully on, all others off.
REQ-018 SHALL treat "fully on" as asserted for every cnt, including duty=PWM_PERIOD; duty=0 as never asserted.
REQ-019 SHALL register led_o one cycle after the cnt/duty_q compare, applying ACTIVE_LOW inversion in that register.
REQ-020 SHALL, with restart_i=1, force state=0, level=0, prescaler=0, cnt=0, duty_q=0 on the next edge, regardless of run_i or period end; no segment_done_o pulse.
REQ-021 SHALL give restart_i priority over a simultaneous segment advance, and reset priority over restart_i.
REQ-022 SHALL, with run_i=0, hold level, prescaler and state but continue cnt and PWM output at the frozen duty.

Reset
REQ-023 SHALL on reset set cnt=0, level=0, prescaler=0, duty_q=0, state_o=0, segment_done_o=0 and led_o to all-inactive ('1 if ACTIVE_LOW, else '0).
REQ-024 SHALL, when reset is asserted mid-segment, abandon it and restart from state 0 on the first cycle after deassertion.

Configuration
REQ-025 SHALL support macro HUE_SEQUENCER_GAMMA_EN: when defined, ramp duty = (level*level)/PWM_PERIOD via a registered square-law stage (extra latency absorbed before period-end reload); when undefined, duty = level linearly. Both modes give duty 0 at level 0 and PWM_PERIOD at level PWM_PERIOD.

Structure
REQ-026 SHALL place in package hue_sequencer_pkg: state width function, ACTIVE_LOW inactive-level constant, and parameter legal-range limits.
REQ-027 SHALL use one sub-module hue_pwm_counter holding cnt, period-end strobe and duty_q reload; all channels share one instance.

Verification (CHANNELS=3, PWM_PERIOD=4, PERIODS_PER_STEP=1, ACTIVE_LOW=1, linear)
REQ-028 SHALL check reset: led_o=3'b111, state_o=0 during reset and on the first cycle after deassertion.
REQ-029 SHALL check timing: run_i=1 -> segment_done_o pulses every 20 cycles; state_o sequence 0..5,0; full wheel 120 cycles.
REQ-030 SHALL check duty: in state 0 at level 2 -> channel 1 low for exactly 2 of 4 cycles; channel 0 low constantly; channel 2 high.
REQ-031 SHALL check freeze: run_i=0 for 50 cycles in state 3 -> state_o and duty unchanged; PWM still toggling.
REQ-032 SHALL check priority: restart_i asserted in the cycle a segment would advance -> state_o=0, no segment_done_o pulse.
REQ-033 SHALL check gamma, macro defined: level 2 -> duty 1, level 4 -> duty 4.

Source files
------------

// File: rtl/hue_sequencer_pkg.sv
// Shared definitions for the hue sequencer colour wheel.
//   state_width()  : width of the hue-state index for a given channel count
//   led_inactive() : idle LED level for a given ACTIVE_LOW setting
//   *_MIN / *_MAX  : legal ranges of the top-level parameters
package hue_sequencer_pkg;

  localparam int CHANNELS_MIN         = 2;
  localparam int CHANNELS_MAX         = 8;
  localparam int PWM_PERIOD_MIN       = 2;
  localparam int PWM_PERIOD_MAX       = 65535;
  localparam int PERIODS_PER_STEP_MIN = 1;
  localparam int PERIODS_PER_STEP_MAX = 255;

  // Idle LED level when the output is active-low.
  localparam logic LED_INACTIVE_ACTIVE_LOW = 1'b1;

  // Each channel owns two states (hold-rising, falling-hold).
  function automatic int state_width(input int channels);
    return $clog2(2 * channels);
  endfunction

  function automatic logic led_inactive(input int active_low);
    return (active_low != 0) ? LED_INACTIVE_ACTIVE_LOW : ~LED_INACTIVE_ACTIVE_LOW;
  endfunction

endpackage

// File: rtl/hue_pwm_counter.sv
// Shared PWM timebase for all LED channels.
//   clk, reset     : clock, synchronous active-high reset
//   restart_i      : forces cnt=0 and duty=0 on the next edge
//   duty_i         : duty value to load at the end of the current period
//   period_end_o   : high while cnt == PWM_PERIOD-1
//   ramp_on_o      : PWM compare (cnt < duty) for the ramping channel
module hue_pwm_counter #(
  parameter int PWM_PERIOD = 46875,
  parameter int LVL_W      = $clog2(PWM_PERIOD + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart_i,
  input  logic [LVL_W-1:0] duty_i,
  output logic             period_end_o,
  output logic             ramp_on_o
);

  localparam int CNT_W = $clog2(PWM_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] duty_q, duty_d;
  logic             period_end;

  assign period_end = (cnt_q == CNT_W'(PWM_PERIOD - 1));

  // Duty only changes at the period boundary so a period never sees two duties.
  always_comb begin
    cnt_d  = period_end ? '0 : cnt_q + 1'b1;
    duty_d = period_end ? duty_i : duty_q;
    if (restart_i) begin
      cnt_d  = '0;
      duty_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end

  assign period_end_o = period_end;
  assign ramp_on_o    = (LVL_W'(cnt_q) < duty_q);

endmodule

// File: rtl/hue_sequencer.sv
// Colour-wheel LED sequencer: cross-fades CHANNELS LEDs around a wheel of
// 2*CHANNELS hue states using one shared PWM timebase.
//   clk, reset      : clock, synchronous active-high reset
//   run_i           : 1 advances brightness, 0 freezes it (PWM keeps running)
//   restart_i       : return to state 0, level 0 on the next edge
//   led_o           : registered LED drive (inverted when ACTIVE_LOW=1)
//   state_o         : current hue state
//   segment_done_o  : one-cycle pulse after each state advance
// Build option: define HUE_SEQUENCER_GAMMA_EN for a square-law ramp
// (duty = x*x/PWM_PERIOD) instead of the default linear ramp.
module hue_sequencer
  import hue_sequencer_pkg::*;
#(
  parameter int CHANNELS         = 3,
  parameter int PWM_PERIOD       = 46875,
  parameter int PERIODS_PER_STEP = 1,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run_i,
  input  logic                             restart_i,
  output logic [CHANNELS-1:0]              led_o,
  output logic [state_width(CHANNELS)-1:0] state_o,
  output logic                             segment_done_o
);

  localparam int   ST_W       = state_width(CHANNELS);
  localparam int   LVL_W      = $clog2(PWM_PERIOD + 1);
  localparam int   PS_W       = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam int   NUM_STATES = 2 * CHANNELS;
  localparam logic LED_OFF    = led_inactive(ACTIVE_LOW);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
      PWM_PERIOD < PWM_PERIOD_MIN || PWM_PERIOD > PWM_PERIOD_MAX ||
      PERIODS_PER_STEP < PERIODS_PER_STEP_MIN ||
      PERIODS_PER_STEP > PERIODS_PER_STEP_MAX) begin : g_bad_params
    $error("hue_sequencer: parameter out of legal range");
  end

  logic [LVL_W-1:0]    level_q, level_d, lvl_stp;
  logic [PS_W-1:0]     presc_q, presc_d, presc_stp;
  logic [ST_W-1:0]     state_q, state_d, st_stp;
  logic                seg_done_q, seg_done_d;
  logic                adv_stp, step;
  logic [LVL_W-1:0]    duty_next;
  logic                period_end, ramp_on;
  logic [CHANNELS-1:0] led_q, led_d, drive;
  int                  lead_ch, next_ch;

  // Even states ramp up with the level, odd states ramp down.
  function automatic logic [LVL_W-1:0] lin_duty(input logic [LVL_W-1:0] lvl,
                                                input logic [ST_W-1:0]  st);
    return st[0] ? (LVL_W'(PWM_PERIOD) - lvl) : lvl;
  endfunction

  hue_pwm_counter #(
    .PWM_PERIOD (PWM_PERIOD),
    .LVL_W      (LVL_W)
  ) u_pwm (
    .clk          (clk),
    .reset        (reset),
    .restart_i    (restart_i),
    .duty_i       (duty_next),
    .period_end_o (period_end),
    .ramp_on_o    (ramp_on)
  );

  // Candidate values if this period end were a brightness step; they depend
  // only on registered state, so they are stable for the whole period.
  always_comb begin
    presc_stp = presc_q + 1'b1;
    lvl_stp   = level_q;
    st_stp    = state_q;
    adv_stp   = 1'b0;
    if (presc_q == PS_W'(PERIODS_PER_STEP - 1)) begin
      presc_stp = '0;
      if (level_q == LVL_W'(PWM_PERIOD)) begin
        lvl_stp = '0;
        adv_stp = 1'b1;
        st_stp  = (state_q == ST_W'(NUM_STATES - 1)) ? '0 : state_q + 1'b1;
      end else begin
        lvl_stp = level_q + 1'b1;
      end
    end
  end

  // Restart overrides any step taken at the same edge.
  always_comb begin
    step       = period_end & run_i;
    level_d    = step ? lvl_stp   : level_q;
    presc_d    = step ? presc_stp : presc_q;
    state_d    = step ? st_stp    : state_q;
    seg_done_d = step & adv_stp;
    if (restart_i) begin
      level_d    = '0;
      presc_d    = '0;
      state_d    = '0;
      seg_done_d = 1'b0;
    end
  end

`ifdef HUE_SEQUENCER_GAMMA_EN
  localparam int SQ_W = 2 * LVL_W;

  function automatic logic [LVL_W-1:0] gamma(input logic [LVL_W-1:0] x);
    logic [SQ_W-1:0] xe;
    logic [SQ_W-1:0] sq;
    xe = {{LVL_W{1'b0}}, x};
    sq = xe * xe;
    return LVL_W'(sq / SQ_W'(PWM_PERIOD));
  endfunction

  // Square-law stage: both possible next duties are precomputed a cycle
  // early; the period-end reload just picks one based on run_i.
  logic [LVL_W-1:0] gamma_stp_q, gamma_stp_d, gamma_hold_q, gamma_hold_d;

  always_comb begin
    gamma_stp_d  = gamma(lin_duty(lvl_stp, st_stp));
    gamma_hold_d = gamma(lin_duty(level_q, state_q));
  end

  always_ff @(posedge clk) begin
    gamma_stp_q  <= gamma_stp_d;
    gamma_hold_q <= gamma_hold_d;
  end

  assign duty_next = run_i ? gamma_stp_q : gamma_hold_q;
`else
  assign duty_next = lin_duty(level_d, state_d);
`endif

  // State 2i: channel i on, channel i+1 ramps up.
  // State 2i+1: channel i ramps down, channel i+1 on.
  always_comb begin
    lead_ch = int'(state_q) / 2;
    next_ch = (lead_ch + 1 == CHANNELS) ? 0 : lead_ch + 1;
    drive   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (c == lead_ch)      drive[c] = state_q[0] ? ramp_on : 1'b1;
      else if (c == next_ch) drive[c] = state_q[0] ? 1'b1 : ramp_on;
    end
    led_d = (ACTIVE_LOW != 0) ? ~drive : drive;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q    <= '0;
      presc_q    <= '0;
      state_q    <= '0;
      seg_done_q <= 1'b0;
      led_q      <= {CHANNELS{LED_OFF}};
    end else begin
      level_q    <= level_d;
      presc_q    <= presc_d;
      state_q    <= state_d;
      seg_done_q <= seg_done_d;
      led_q      <= led_d;
    end
  end

  assign led_o          = led_q;
  assign state_o        = state_q;
  assign segment_done_o = seg_done_q;

endmodule

// File: tb/tb_hue_sequencer.sv
module tb_hue_sequencer;

  localparam int CH  = 3;
  localparam int P   = 4;
  localparam int PPS = 1;

  logic       clk = 1'b0;
  logic       reset, run_i, restart_i;
  logic [2:0] led_o;
  logic [2:0] state_o;
  logic       segment_done_o;

  always #5 clk = ~clk;

  hue_sequencer #(
    .CHANNELS         (CH),
    .PWM_PERIOD       (P),
    .PERIODS_PER_STEP (PPS),
    .ACTIVE_LOW       (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run_i          (run_i),
    .restart_i      (restart_i),
    .led_o          (led_o),
    .state_o        (state_o),
    .segment_done_o (segment_done_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integers following the wheel rules.
  int         m_cnt, m_level, m_presc, m_state, m_duty;
  logic [2:0] m_led;
  bit         m_seg;

  function automatic int ramp_duty(input int lvl, input int st);
    int x;
    x = (st % 2 == 1) ? P - lvl : lvl;
`ifdef HUE_SEQUENCER_GAMMA_EN
    return (x * x) / P;
`else
    return x;
`endif
  endfunction

  function automatic logic [2:0] model_lit();
    logic [2:0] lit;
    int lead, nxt;
    bit ramp;
    lit  = '0;
    lead = m_state / 2;
    nxt  = (lead + 1) % CH;
    ramp = (m_cnt < m_duty);
    if (m_state % 2 == 0) begin
      lit[lead] = 1'b1;
      lit[nxt]  = ramp;
    end else begin
      lit[lead] = ramp;
      lit[nxt]  = 1'b1;
    end
    return lit;
  endfunction

  task automatic model_edge(input bit rst, input bit run, input bit rs);
    bit pe;
    if (rst) begin
      m_cnt = 0; m_level = 0; m_presc = 0; m_state = 0; m_duty = 0;
      m_seg = 0; m_led = 3'b111;
    end else begin
      m_led = ~model_lit();
      m_seg = 0;
      if (rs) begin
        m_cnt = 0; m_level = 0; m_presc = 0; m_state = 0; m_duty = 0;
      end else begin
        pe    = (m_cnt == P - 1);
        m_cnt = pe ? 0 : m_cnt + 1;
        if (pe && run) begin
          m_presc++;
          if (m_presc == PPS) begin
            m_presc = 0;
            if (m_level == P) begin
              m_level = 0;
              m_state = (m_state + 1) % (2 * CH);
              m_seg   = 1;
            end else begin
              m_level++;
            end
          end
        end
        if (pe) m_duty = ramp_duty(m_level, m_state);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit rst, input bit run, input bit rs);
    reset = rst; run_i = run; restart_i = rs;
    @(posedge clk);
    model_edge(rst, run, rs);
    @(negedge clk);
    check("model_led", led_o, m_led);
    check("model_state", state_o, m_state);
    check("model_seg", segment_done_o, m_seg);
  endtask

  typedef struct {
    bit         rst;
    bit         run;
    bit         rs;
    logic [2:0] led;
    int         state;
    bit         seg;
  } vec_t;

  vec_t       tbl[23];
  logic [2:0] led_ref[1:21];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lows;
    reset = 1'b1; run_i = 1'b0; restart_i = 1'b0;

    // Expected active-low LED drive for edges 1..21 after reset release.
`ifdef HUE_SEQUENCER_GAMMA_EN
    led_ref = '{3'b110, 3'b110, 3'b110, 3'b110,
                3'b110, 3'b110, 3'b110, 3'b110,
                3'b100, 3'b110, 3'b110, 3'b110,
                3'b100, 3'b100, 3'b110, 3'b110,
                3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`else
    led_ref = '{3'b110, 3'b110, 3'b110, 3'b110,
                3'b100, 3'b110, 3'b110, 3'b110,
                3'b100, 3'b100, 3'b110, 3'b110,
                3'b100, 3'b100, 3'b100, 3'b110,
                3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`endif
    tbl[0] = '{rst: 1, run: 0, rs: 0, led: 3'b111, state: 0, seg: 0};
    tbl[1] = '{rst: 1, run: 0, rs: 0, led: 3'b111, state: 0, seg: 0};
    for (int k = 2; k < 23; k++)
      tbl[k] = '{rst: 0, run: 1, rs: 0, led: led_ref[k-1],
                 state: (k - 1 >= 20) ? 1 : 0, seg: (k - 1 == 20)};

    for (int k = 0; k < 23; k++) begin
      if (k == 2) begin
        reset = 1'b0; run_i = 1'b1;
        #1;
        check("deassert_led", led_o, 3'b111);
        check("deassert_state", state_o, 0);
      end
      tick(tbl[k].rst, tbl[k].run, tbl[k].rs);
      check("tbl_led", led_o, tbl[k].led);
      check("tbl_state", state_o, tbl[k].state);
      check("tbl_seg", segment_done_o, tbl[k].seg);
    end

    // Rest of the wheel: pulse every 20 edges, states 0..5 then back to 0.
    for (int e = 22; e <= 120; e++) begin
      tick(0, 1, 0);
      check("wheel_seg", segment_done_o, (e % 20 == 0));
      check("wheel_state", state_o, (e / 20) % 6);
    end

    // Freeze in state 3 at level 2.
    tick(0, 1, 1);
    repeat (70) tick(0, 1, 0);
    check("freeze_entry_state", state_o, 3);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      tick(0, 0, 0);
      check("freeze_state", state_o, 3);
      check("freeze_ch2_on", led_o[2], 0);
      if (i < 48 && led_o[1] == 1'b0) lows++;
    end
`ifdef HUE_SEQUENCER_GAMMA_EN
    check("freeze_ch1_low_count", lows, 12);
`else
    check("freeze_ch1_low_count", lows, 24);
`endif

    // Restart on the edge that would advance the segment.
    tick(0, 1, 1);
    repeat (19) tick(0, 1, 0);
    check("prio_pre_state", state_o, 0);
    tick(0, 1, 1);
    check("prio_state", state_o, 0);
    check("prio_seg", segment_done_o, 0);
    tick(0, 1, 0);
    check("prio_seg_after", segment_done_o, 0);
    check("prio_state_after", state_o, 0);

    // Randomised run/restart/reset against the model.
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
